// File: rtl/mul_seq_ctrl.sv
// Unsigned WIDTH x WIDTH multiplier that walks every 2-bit digit pair through one 2x2 multiplier.
// Result valid N*N edges after acceptance, held in DONE until taken; operands refused while busy.

module mul2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);
  assign p = {2'b00, x} * {2'b00, y};
endmodule

module mul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   r,
  output logic                 busy
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, r_q, r_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [1:0]           a_dig, b_dig;
  logic [3:0]           p;
  logic [2*WIDTH-1:0]   p_ext;
  logic [IW:0]          dsum;

  assign a_dig = a_q[{i_q, 1'b0} +: 2];
  assign b_dig = b_q[{j_q, 1'b0} +: 2];

  mul2x2 u_mul (
    .x (a_dig),
    .y (b_dig),
    .p (p)
  );

  // Partial product weight is 4^(i+j); shift by twice the digit-index sum.
  always_comb begin
    p_ext      = '0;
    p_ext[3:0] = p;
    dsum       = {1'b0, i_q} + {1'b0, j_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    r_d     = r_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + (p_ext << {dsum, 1'b0});
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + IW'(1);
          if (i_q == LAST) begin
            i_d     = '0;
            r_d     = acc_d;
            state_d = DONE;
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      r_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      i_q         <= i_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign r         = r_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: transaction-level model checked every cycle plus directed literal checks.
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] r;

  logic        iv2, ir2, ov2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  r2;
  logic        iv16, ir16, ov16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] r16;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .busy(busy)
  );
  mul_seq_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(1'b1), .r(r2), .busy(busy2)
  );
  mul_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(1'b1), .r(r16), .busy(busy16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an accepted pair becomes a*b exactly 16 edges later, held until taken.
  bit          m_ready = 1'b1;
  bit          m_valid = 1'b0;
  logic [15:0] m_r = '0;
  logic [15:0] m_prod = '0;
  int          m_cnt = 0;
  int          m_deliv = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_r     = '0;
      m_cnt   = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
        m_deliv++;
      end
    end else if (m_ready) begin
      if (in_valid) begin
        m_prod  = 16'(a) * 16'(b);
        m_cnt   = 16;
        m_ready = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_r     = m_prod;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cyc in_ready", in_ready, m_ready);
      check("cyc out_valid", out_valid, m_valid);
      check("cyc busy", busy, !m_ready);
      check("cyc r", r, m_r);
    end
  end

  task automatic start_op(input logic [7:0] x, input logic [7:0] y);
    bit ok = 1'b0;
    bit rdy;
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      rdy = in_ready;
      @(posedge clk);
      ok = rdy;
      if (!ok) @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y;
    check("accept", ok, 1);
  endtask

  task automatic wait_done(input string name, input logic [15:0] exp_r);
    int edges = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (out_valid) break;
    end
    check({name, " latency"}, edges, 16);
    check({name, " r"}, r, exp_r);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("take out_valid", out_valid, 0);
    check("take in_ready", in_ready, 1);
  endtask

  initial begin
    int d0;
    int e;
    rst = 1'b1; in_valid = 0; out_ready = 0; a = 0; b = 0;
    iv2 = 0; a2 = 0; b2 = 0; iv16 = 0; a16 = 0; b16 = 0;
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst r", r, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    start_op(8'd3, 8'd2);     wait_done("t1", 16'd6);      take();
    start_op(8'd255, 8'd255); wait_done("t2a", 16'hFE01);  take();
    start_op(8'd0, 8'd173);   wait_done("t2b", 16'd0);     take();
    start_op(8'd170, 8'd85);  wait_done("t2c", 16'd14450); take();

    start_op(8'd255, 8'd2);   wait_done("t3", 16'd510);
    for (int k = 0; k < 5; k++) begin
      check("t3 hold valid", out_valid, 1);
      check("t3 hold r", r, 16'd510);
      in_valid = (k % 2 == 0); a = 8'd7; b = 8'd7;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    take();

    out_ready = 1'b1;
    start_op(8'd12, 8'd34);
    in_valid = 1'b1; a = 8'd200; b = 8'd201;
    wait_done("t4a", 16'd408);
    @(posedge clk);
    @(negedge clk);
    check("t4 idle after delivery", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("t4 second accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_done("t4b", 16'd40200);
    take();

    start_op(8'd154, 8'd60);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5 out_valid", out_valid, 0);
    check("t5 busy", busy, 0);
    check("t5 r", r, 0);
    check("t5 in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    start_op(8'd9, 8'd9); wait_done("t5 after", 16'd81); take();

    d0 = m_deliv;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = (k % 50 == 0) ? 8'hFF : 8'($urandom);
      b = (k % 70 == 0) ? 8'hFF : 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand progress", (m_deliv - d0) >= 5, 1);

    @(negedge clk);
    check("w2 ready", ir2, 1);
    a2 = 2'd3; b2 = 2'd3; iv2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    e = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (ov2) break;
    end
    check("w2 latency", e, 1);
    check("w2 r", r2, 4'd9);

    check("w16 ready", ir16, 1);
    a16 = 16'hFFFF; b16 = 16'hFFFF; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    e = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (ov16) break;
    end
    check("w16 latency", e, 64);
    check("w16 r", r16, 32'hFFFE0001);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
